key_debounce: RTL and testbench

KEY_DEBOUNCE -- requirements
Module: key_debounce

---
 rtl/key_debounce.sv | 130 +++++++++++++
 tb/tb_key_debounce.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_debounce.sv
// Keypad debouncer: 2-flop synchronizer feeding a four-state press/release FSM
// with optional auto-repeat. All outputs come straight from flops.
module key_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 500000,
   parameter int unsigned REPEAT_DELAY    = 0,
   parameter int unsigned REPEAT_RATE     = 5000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] key_in,
   output logic [3:0] key_out,
   output logic       key_press,
   output logic       key_release,
   output logic       key_held
);

   localparam logic [3:0]  NO_KEY = 4'b1111;
   localparam int unsigned MAX_DR = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
   localparam int unsigned MAXP   = (MAX_DR > REPEAT_RATE) ? MAX_DR : REPEAT_RATE;
   localparam int unsigned CW     = (MAXP < 2) ? 1 : $clog2(MAXP);
   localparam bit          REPEAT_EN = (REPEAT_DELAY > 0);

   localparam logic [CW-1:0] DEB_LAST = CW'((DEBOUNCE_CYCLES == 0) ? 0 : DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0] RD_LAST  = CW'((REPEAT_DELAY == 0) ? 0 : REPEAT_DELAY - 1);
   localparam logic [CW-1:0] RR_LAST  = CW'((REPEAT_RATE == 0) ? 0 : REPEAT_RATE - 1);

   typedef enum logic [1:0] {
      IDLE,
      PRESS_WAIT,
      HELD,
      RELEASE_WAIT
   } state_t;

   state_t          r_state;
   logic [3:0]      r_sync1;
   logic [3:0]      r_sync2;
   logic [3:0]      r_cand;
   logic [CW-1:0]   r_cnt;
   logic [CW-1:0]   r_rcnt;
   logic            r_rep_phase;

   logic [3:0]      w_sample;
   logic [CW-1:0]   w_cnt_inc;
   logic [CW-1:0]   w_rcnt_inc;
   logic [CW-1:0]   w_rep_last;

   assign w_sample   = r_sync2;
   assign w_cnt_inc  = (r_cnt  == '1) ? r_cnt  : r_cnt  + 1'b1;
   assign w_rcnt_inc = (r_rcnt == '1) ? r_rcnt : r_rcnt + 1'b1;
   // First repeat waits REPEAT_DELAY, later ones REPEAT_RATE.
   assign w_rep_last = r_rep_phase ? RR_LAST : RD_LAST;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_sync1     <= NO_KEY;
         r_sync2     <= NO_KEY;
         r_cand      <= NO_KEY;
         r_cnt       <= '0;
         r_rcnt      <= '0;
         r_rep_phase <= 1'b0;
         key_out     <= NO_KEY;
         key_press   <= 1'b0;
         key_release <= 1'b0;
         key_held    <= 1'b0;
      end else begin
         r_sync1     <= key_in;
         r_sync2     <= r_sync1;
         key_press   <= 1'b0;
         key_release <= 1'b0;

         case (r_state)
            IDLE: begin
               if (w_sample != NO_KEY) begin
                  r_cand  <= w_sample;
                  r_cnt   <= '0;
                  r_state <= PRESS_WAIT;
               end
            end

            PRESS_WAIT: begin
               if (w_sample != r_cand) begin
                  r_state <= IDLE;
               end else if (r_cnt == DEB_LAST) begin
                  r_state     <= HELD;
                  key_out     <= r_cand;
                  key_held    <= 1'b1;
                  key_press   <= 1'b1;
                  r_rcnt      <= '0;
                  r_rep_phase <= 1'b0;
               end else begin
                  r_cnt <= w_cnt_inc;
               end
            end

            HELD: begin
               // Any code other than the accepted one, idle or not, starts a release.
               if (w_sample != key_out) begin
                  r_cnt   <= '0;
                  r_state <= RELEASE_WAIT;
               end else if (REPEAT_EN) begin
                  if (r_rcnt == w_rep_last) begin
                     key_press   <= 1'b1;
                     r_rcnt      <= '0;
                     r_rep_phase <= 1'b1;
                  end else begin
                     r_rcnt <= w_rcnt_inc;
                  end
               end
            end

            RELEASE_WAIT: begin
               if (w_sample == key_out) begin
                  r_state <= HELD;
               end else if (r_cnt == DEB_LAST) begin
                  r_state     <= IDLE;
                  key_out     <= NO_KEY;
                  key_held    <= 1'b0;
                  key_release <= 1'b1;
               end else begin
                  r_cnt <= w_cnt_inc;
               end
            end

            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce: two instances (no repeat / repeat 20,10) checked every
// cycle against a timestamp-based reference model, plus directed latency checks.
module tb_key_debounce;

   localparam int DEB = 8;
   localparam logic [3:0] NK = 4'b1111;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] key_in;
   logic [3:0] ko0, ko1;
   logic       press0, press1, rel0, rel1, held0, held1;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   key_debounce #(.DEBOUNCE_CYCLES(DEB), .REPEAT_DELAY(0), .REPEAT_RATE(10)) u_dut0 (
      .clk(clk), .rst(rst), .key_in(key_in), .key_out(ko0),
      .key_press(press0), .key_release(rel0), .key_held(held0));

   key_debounce #(.DEBOUNCE_CYCLES(DEB), .REPEAT_DELAY(20), .REPEAT_RATE(10)) u_dut1 (
      .clk(clk), .rst(rst), .key_in(key_in), .key_out(ko1),
      .key_press(press1), .key_release(rel1), .key_held(held1));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // The accepted key changes only after the synchronized value has been seen
   // steady for DEB edges beyond the edge that first noticed it; repeats are
   // scheduled from the count of matching held edges.
   int         cyc = 0;
   bit         m_valid = 1'b0;
   logic [3:0] m_s1, m_s2, s_cur;
   logic [3:0] m_key   [2];
   bit         m_pend  [2];
   logic [3:0] m_pcode [2];
   int         m_pstart[2];
   bit         m_rel   [2];
   int         m_rstart[2];
   int         m_ht    [2];
   logic [3:0] e_out   [2];
   bit         e_press [2];
   bit         e_rel   [2];
   bit         e_held  [2];

   function automatic int rd_of(input int d);
      return (d == 0) ? 0 : 20;
   endfunction

   task automatic model_reset(input int d);
      m_key[d] = NK; m_pend[d] = 0; m_pcode[d] = NK; m_pstart[d] = 0;
      m_rel[d] = 0; m_rstart[d] = 0; m_ht[d] = 0;
      e_out[d] = NK; e_press[d] = 0; e_rel[d] = 0; e_held[d] = 0;
   endtask

   task automatic model_step(input int d, input logic [3:0] s);
      int rd;
      rd = rd_of(d);
      e_press[d] = 0;
      e_rel[d]   = 0;
      if (m_key[d] == NK) begin
         if (m_pend[d]) begin
            if (s == m_pcode[d]) begin
               if (cyc - m_pstart[d] == DEB) begin
                  m_key[d] = m_pcode[d]; m_pend[d] = 0; m_rel[d] = 0;
                  m_ht[d] = 0; e_press[d] = 1;
               end
            end else begin
               m_pend[d] = 0;
            end
         end else if (s != NK) begin
            m_pend[d] = 1; m_pcode[d] = s; m_pstart[d] = cyc;
         end
      end else begin
         if (m_rel[d]) begin
            if (s == m_key[d]) m_rel[d] = 0;
            else if (cyc - m_rstart[d] == DEB) begin
               m_key[d] = NK; m_rel[d] = 0; e_rel[d] = 1;
            end
         end else if (s != m_key[d]) begin
            m_rel[d] = 1; m_rstart[d] = cyc;
         end else if (rd > 0) begin
            m_ht[d]++;
            if (m_ht[d] == rd || (m_ht[d] > rd && (m_ht[d] - rd) % 10 == 0)) e_press[d] = 1;
         end
      end
      e_out[d]  = m_key[d];
      e_held[d] = (m_key[d] != NK);
   endtask

   always @(posedge clk) begin
      cyc++;
      if (rst) begin
         m_s1 = NK; m_s2 = NK; m_valid = 1'b1;
         model_reset(0); model_reset(1);
      end else begin
         s_cur = m_s2; m_s2 = m_s1; m_s1 = key_in;
         model_step(0, s_cur);
         model_step(1, s_cur);
      end
   end

   always @(negedge clk) begin
      if (m_valid) begin
         chk("key_out0", {28'd0, ko0}, {28'd0, e_out[0]});
         chk("press0",   {31'd0, press0}, {31'd0, e_press[0]});
         chk("release0", {31'd0, rel0},   {31'd0, e_rel[0]});
         chk("held0",    {31'd0, held0},  {31'd0, e_held[0]});
         chk("key_out1", {28'd0, ko1}, {28'd0, e_out[1]});
         chk("press1",   {31'd0, press1}, {31'd0, e_press[1]});
         chk("release1", {31'd0, rel1},   {31'd0, e_rel[1]});
         chk("held1",    {31'd0, held1},  {31'd0, e_held[1]});
         chk("excl0", {31'd0, press0 & rel0}, 32'd0);
         chk("excl1", {31'd0, press1 & rel1}, 32'd0);
      end
   end

   // ---------------- directed helpers ----------------
   function automatic logic pulse_of(input int which, input int kind);
      if (which == 0) return (kind == 0) ? press0 : rel0;
      return (kind == 0) ? press1 : rel1;
   endfunction

   task automatic wait_pulse(input int which, input int kind, input int limit, output int n);
      n = -1;
      for (int i = 1; i <= limit && n < 0; i++) begin
         @(posedge clk); #1;
         if (pulse_of(which, kind) === 1'b1) n = i;
      end
   endtask

   task automatic step(input int k, output int p);
      p = 0;
      for (int i = 0; i < k; i++) begin
         @(posedge clk); #1;
         p += int'(press0 === 1'b1) + int'(rel0 === 1'b1);
      end
   endtask

   int n, p, rep_n, p0;
   int offs[4];

   initial begin
      rst = 1'b1;
      key_in = NK;
      step(3, p);
      chk("rst_key_out", {28'd0, ko0}, {28'd0, NK});
      chk("rst_held", {31'd0, held0}, 32'd0);
      chk("rst_press", {31'd0, press0}, 32'd0);
      rst = 1'b0;
      step(5, p);

      // clean press, auto-repeat on the second instance, clean release
      key_in = 4'b0010;
      wait_pulse(0, 0, 30, n);
      chk("clean_press_lat", n, 11);
      chk("clean_key_out", {28'd0, ko0}, 32'h2);
      chk("clean_held", {31'd0, held0}, 32'd1);
      rep_n = 0; p0 = 0;
      for (int i = 1; i <= 55; i++) begin
         @(posedge clk); #1;
         if (press1 === 1'b1) begin
            if (rep_n < 4) offs[rep_n] = i;
            rep_n++;
         end
         if (press0 === 1'b1) p0++;
      end
      chk("rep_count", rep_n, 4);
      chk("rep_off20", offs[0], 20);
      chk("rep_off30", offs[1], 30);
      chk("rep_off40", offs[2], 40);
      chk("rep_off50", offs[3], 50);
      chk("no_repeat_dut0", p0, 0);
      key_in = NK;
      wait_pulse(0, 1, 30, n);
      chk("clean_release_lat", n, 11);
      chk("release_key_out", {28'd0, ko0}, {28'd0, NK});
      chk("release_held", {31'd0, held0}, 32'd0);
      step(5, p);

      // bouncing contact
      p0 = 0;
      for (int seg = 0; seg < 10; seg++) begin
         key_in = (seg % 2 == 0) ? 4'b1101 : NK;
         step(3, p);
         p0 += p;
      end
      chk("bounce_no_pulse", p0, 0);
      key_in = 4'b1101;
      wait_pulse(0, 0, 30, n);
      chk("bounce_press_lat", n, 11);
      chk("bounce_key_out", {28'd0, ko0}, 32'hD);
      key_in = NK;
      wait_pulse(0, 1, 30, n);
      chk("bounce_release_lat", n, 11);
      step(4, p);

      // short release glitch while held
      key_in = 4'b0010;
      wait_pulse(0, 0, 30, n);
      chk("glitch_press_lat", n, 11);
      step(5, p);
      key_in = NK;
      step(4, p);
      key_in = 4'b0010;
      step(20, p0);
      chk("glitch_no_pulse", p + p0, 0);
      chk("glitch_key_out", {28'd0, ko0}, 32'h2);
      chk("glitch_held", {31'd0, held0}, 32'd1);

      // direct change to another key
      key_in = 4'b1101;
      wait_pulse(0, 1, 30, n);
      chk("change_release_lat", n, 11);
      wait_pulse(0, 0, 30, n);
      chk("change_press_lat", n, 9);
      chk("change_key_out", {28'd0, ko0}, 32'hD);

      // reset while held
      key_in = 4'b0010;
      wait_pulse(0, 1, 30, n);
      wait_pulse(0, 0, 30, n);
      chk("pre_rst_press_lat", n, 9);
      step(3, p);
      rst = 1'b1;
      step(2, p);
      chk("rst_hold_no_pulse", p, 0);
      chk("rst_hold_key_out", {28'd0, ko0}, {28'd0, NK});
      chk("rst_hold_held", {31'd0, held0}, 32'd0);
      rst = 1'b0;
      wait_pulse(0, 0, 30, n);
      chk("post_rst_press_lat", n, 11);
      key_in = NK;
      step(20, p);

      // randomized traffic, model-checked each cycle
      for (int blk = 0; blk < 300; blk++) begin
         int r;
         r = $urandom_range(0, 19);
         if (r == 19) begin
            rst = 1'b1;
            step(1, p);
            rst = 1'b0;
         end else begin
            if (r < 7)       key_in = NK;
            else if (r < 11) key_in = 4'b0010;
            else if (r < 15) key_in = 4'b1101;
            else             key_in = 4'($urandom_range(0, 15));
            step((r % 2 == 0) ? $urandom_range(1, 6) : $urandom_range(6, 30), p);
         end
      end
      key_in = NK;
      step(30, p);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
